// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the fetch unit and the Controller: opcode encodings
// and the fetch state encoding.
package riscv_ctrl_pkg;

  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] I_TYPE  = 7'b0010011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;
  localparam logic [6:0] SB_TYPE = 7'b1100011;
  localparam logic [6:0] LOAD    = 7'b0000011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_opcode_check.sv
// Combinational legality decode of a fetched opcode; only built when
// FETCH_OPCODE_CHECK_EN is defined.
`ifdef FETCH_OPCODE_CHECK_EN
module fetch_opcode_check
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      R_TYPE, I_TYPE, S_TYPE, SB_TYPE, LOAD: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch with branch redirect and a single outstanding
// memory request. FETCH_OPCODE_CHECK_EN adds an illegal-opcode HALT state.
module instr_fetch_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [6:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target
`ifdef FETCH_OPCODE_CHECK_EN
  ,
  output logic              illegal
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              drop;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  // Wraps modulo 2^ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(4);
  endfunction

`ifdef FETCH_OPCODE_CHECK_EN
  logic word_legal;

  fetch_opcode_check u_opcode_check (
    .opcode (imem_rdata[6:0]),
    .legal  (word_legal)
  );

  assign illegal = (state == HALT);
`endif

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);
  assign opcode      = instr[6:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= REQ;
        end
        REQ: begin
          if (branch_taken) pc <= align_pc(branch_target);
          // A grant in the redirect cycle still owes a response, which must be discarded.
          if (imem_gnt) begin
            state <= WAIT;
            drop  <= branch_taken;
          end
        end
        WAIT: begin
          if (branch_taken) pc <= align_pc(branch_target);
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (drop || branch_taken) begin
              state <= REQ;
            end else begin
              instr    <= imem_rdata;
              instr_pc <= pc;
`ifdef FETCH_OPCODE_CHECK_EN
              state    <= word_legal ? ISSUE : HALT;
`else
              state    <= ISSUE;
`endif
            end
          end else if (branch_taken) begin
            drop <= 1'b1;
          end
        end
        ISSUE: begin
          // Redirect wins over the sequential successor even when the word is consumed.
          if (branch_taken) begin
            pc    <= align_pc(branch_target);
            state <= REQ;
          end else if (instr_ready) begin
            pc    <= seq_pc(pc);
            state <= REQ;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model answers fetches, a
// monitor compares every granted address and every issued instruction.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, branch_target;
  logic        instr_valid, instr_ready, branch_taken;
  logic [6:0]  opcode;

  logic        reset2, start2, imem_req2, instr_valid2;
  logic [31:0] imem_addr2, instr2, instr_pc2;
  logic [6:0]  opcode2;

`ifdef FETCH_OPCODE_CHECK_EN
  logic        illegal, illegal2;
`endif

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
    .branch_taken(branch_taken), .branch_target(branch_target)
`ifdef FETCH_OPCODE_CHECK_EN
    , .illegal(illegal)
`endif
  );

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset2), .start(start2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(1'b1),
    .imem_rvalid(1'b1), .imem_rdata(32'h0020_8033),
    .instr_valid(instr_valid2), .instr_ready(1'b1),
    .instr(instr2), .opcode(opcode2), .instr_pc(instr_pc2),
    .branch_taken(1'b0), .branch_target(32'h0)
`ifdef FETCH_OPCODE_CHECK_EN
    , .illegal(illegal2)
`endif
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_instr_q[$];
  logic [31:0] exp_addr_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          rv_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic push_instr(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    e.word = w;
    e.pc   = p;
    exp_instr_q.push_back(e);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0020_8033;
      32'h0000_0004: return 32'h0040_0093;
      32'h0000_0008: return 32'h0020_a023;
      32'h0000_0040: return 32'h0011_0113;
      32'h0000_0044: return 32'h00c1_2183;
      32'h0000_0100: return 32'h0000_2083;
      32'hFFFF_FFFC: return 32'h0000_0063;
      32'h0000_0200: return 32'hFFFF_FFFF;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  // Memory: grants immediately, answers rv_delay cycles after the grant.
  initial begin
    logic        pend, last_hs, last_rv;
    logic [31:0] pend_addr, last_addr;
    int          pend_wait;
    pend = 1'b0; last_hs = 1'b0; last_rv = 1'b0;
    pend_addr = '0; last_addr = '0; pend_wait = 0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0; last_hs = 1'b0; last_rv = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
      end else begin
        if (last_rv) pend = 1'b0;
        if (last_hs) begin
          pend = 1'b1; pend_addr = last_addr; pend_wait = rv_delay;
        end
        imem_rvalid = 1'b0;
        if (pend) begin
          if (pend_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
          end else begin
            pend_wait--;
          end
        end
        imem_gnt  = imem_req && !pend;
        last_hs   = imem_req && imem_gnt;
        last_addr = imem_addr;
        last_rv   = imem_rvalid;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (imem_req && imem_gnt) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_req: got addr %h, required no request", imem_addr);
          end else begin
            check("req_addr", imem_addr, exp_addr_q.pop_front());
          end
        end
        if (instr_valid && instr_ready) begin
          if (exp_instr_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_issue: got instr %h pc %h, required none", instr, instr_pc);
          end else begin
            e = exp_instr_q.pop_front();
            check("issue_instr", instr, e.word);
            check("issue_opcode", 32'(opcode), 32'(e.word[6:0]));
            check("issue_pc", instr_pc, e.pc);
          end
        end
      end
    end
  end

  task automatic wait_valid(input string name);
    int i = 0;
    while (!instr_valid && i < 50) begin
      @(negedge clk);
      #1;
      i++;
    end
    check({name, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic consume(input logic br, input logic [31:0] tgt);
    wait_valid("consume");
    @(negedge clk);
    instr_ready   = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    @(negedge clk);
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int i;
    reset = 1'b1; reset2 = 1'b1; start = 1'b0; start2 = 1'b0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst2_addr", imem_addr2, 32'hFFFF_FFFC);
`ifdef FETCH_OPCODE_CHECK_EN
    check("rst_illegal", 32'(illegal), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;

    // First fetch: best-case latency.
    exp_addr_q.push_back(32'h0);
    push_instr(32'h0020_8033, 32'h0);
    @(negedge clk);
    start = 1'b1;
    #1;
    lat = 0;
    while (!instr_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("first_latency", 32'(lat), 32'd3);
    check("first_opcode", 32'(opcode), 32'(7'b0110011));
    check("first_pc", instr_pc, 32'h0);
    exp_addr_q.push_back(32'h4);
    consume(1'b0, 32'h0);

    // Stall in ISSUE for five cycles.
    push_instr(32'h0040_0093, 32'h4);
    wait_valid("stall");
    repeat (5) begin
      @(negedge clk);
      #1;
      check("stall_instr", instr, 32'h0040_0093);
      check("stall_opcode", 32'(opcode), 32'(7'b0010011));
      check("stall_pc", instr_pc, 32'h4);
      check("stall_no_req", 32'(imem_req), 32'd0);
    end
    exp_addr_q.push_back(32'h8);
    push_instr(32'h0020_a023, 32'h8);
    consume(1'b0, 32'h0);

    // Redirect coinciding with the handshake at pc 8.
    exp_addr_q.push_back(32'h40);
    consume(1'b1, 32'h40);
    push_instr(32'h0011_0113, 32'h40);
    rv_delay = 2;
    exp_addr_q.push_back(32'h44);
    consume(1'b0, 32'h0);

    // Redirect while the 0x44 response is still owed.
    i = 0;
    while (!(imem_req && imem_gnt) && i < 20) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("wait_grant", 32'(imem_req && imem_gnt), 32'd1);
    @(negedge clk);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0103;
    exp_addr_q.push_back(32'h100);
    #1;
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    i = 0;
    while (!imem_req && i < 20) begin
      check("drop_no_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      #1;
      i++;
    end
    check("drop_addr", imem_addr, 32'h100);
    rv_delay = 0;
    push_instr(32'h0000_2083, 32'h100);

    // Wrap from the top of the address space.
    exp_addr_q.push_back(32'hFFFF_FFFC);
    consume(1'b1, 32'hFFFF_FFFF);
    push_instr(32'h0000_0063, 32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    consume(1'b0, 32'h0);
    push_instr(32'h0020_8033, 32'h0);
    exp_addr_q.push_back(32'h200);
    consume(1'b1, 32'h200);

`ifdef FETCH_OPCODE_CHECK_EN
    i = 0;
    while (!illegal && i < 20) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("halt_illegal", 32'(illegal), 32'd1);
    repeat (5) begin
      @(negedge clk);
      #1;
      check("halt_valid", 32'(instr_valid), 32'd0);
      check("halt_no_req", 32'(imem_req), 32'd0);
      check("halt_instr", instr, 32'hFFFF_FFFF);
      check("halt_pc", instr_pc, 32'h200);
    end
`else
    push_instr(32'hFFFF_FFFF, 32'h200);
    exp_addr_q.push_back(32'h204);
    consume(1'b0, 32'h0);
    repeat (4) @(negedge clk);
    #1;
`endif

    // Second instance starts at 0xFFFF_FFFC and must wrap to 0.
    @(negedge clk);
    reset2 = 1'b0;
    start2 = 1'b1;
    #1;
    i = 0;
    while (!instr_valid2 && i < 20) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("rpc_valid", 32'(instr_valid2), 32'd1);
    check("rpc_pc", instr_pc2, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    check("rpc_next_req", 32'(imem_req2), 32'd1);
    check("rpc_next_addr", imem_addr2, 32'h0);

    check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    check("instr_queue_empty", 32'(exp_instr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction source for the single-cycle RISC-V datapath. It owns the PC, fetches 32-bit words from instruction memory over a request/grant/response handshake, and presents each word with its 7-bit opcode to the Controller over a valid/ready handshake. It is the producer side of the opcode interface the Controller consumes. It also accepts branch redirects from the datapath and discards in-flight or pending fetches when one arrives.

## Interface
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; leaves IDLE when sampled high
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address, word aligned
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  read data valid
- imem_rdata  in  DATA_W  read data
- instr_valid  out  1  instruction available to Controller
- instr_ready  in  1  Controller accepts instruction
- instr  out  DATA_W  held instruction word
- opcode  out  7  instr[6:0], drives Controller Opcode
- instr_pc  out  ADDR_W  PC of held instruction
- branch_taken  in  1  redirect request, single-cycle pulse
- branch_target  in  ADDR_W  redirect address
- illegal  out  1  present only with FETCH_OPCODE_CHECK_EN

## Operation
- States: IDLE, REQ, WAIT, ISSUE, HALT.
- IDLE: all handshake outputs low. start=1 -> REQ.
- REQ: imem_req=1, imem_addr=pc. imem_gnt=1 -> WAIT. The request holds stable until granted.
- WAIT: imem_req=0. imem_rvalid=1 -> latch imem_rdata into instr, latch pc into instr_pc, go to ISSUE.
- ISSUE: instr_valid=1. instr, opcode and instr_pc hold stable while valid and not ready. On instr_valid & instr_ready: pc <= pc+4, go to REQ.
- Redirect (branch_taken=1) in REQ, WAIT or ISSUE: pc <= {branch_target[ADDR_W-1:2],2'b00}, go to REQ.
  - In WAIT: the outstanding response is owed. Set the drop flag. The state stays WAIT until rvalid arrives. That response is discarded, then the state goes to REQ at the new pc.
  - In ISSUE: the held instruction is withdrawn and instr_valid falls next cycle.
  - Redirect coinciding with a handshake in ISSUE: the instruction counts as consumed and the redirect target wins over pc+4.
  - In REQ with gnt the same cycle: the grant is honoured, the response is dropped as in WAIT, and the next request uses the target.
- Redirect in IDLE or HALT is ignored.
- PC arithmetic is modulo 2^ADDR_W. 32'hFFFF_FFFC + 4 = 0.
- start is ignored outside IDLE.

## Timing
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, drop=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, opcode=0, instr_pc=0, illegal=0.
- Reset mid-fetch abandons the outstanding response. The memory side must tolerate this.
- Best case is 3 cycles per instruction: REQ (gnt same cycle), WAIT (rvalid next cycle), ISSUE (ready same cycle).
- Response to valid: instr_valid rises on the cycle after imem_rvalid.
- At most one outstanding memory request. imem_rvalid outside WAIT is ignored.
- All outputs are registered or decoded from state only. There is no combinational path from instr_ready to imem_req.

## Configuration
- FETCH_OPCODE_CHECK_EN defined:
  - A latched word whose opcode is not R_TYPE, I_TYPE, S_TYPE, SB_TYPE or LOAD goes to HALT instead of ISSUE.
  - In HALT: illegal=1, instr and instr_pc hold the offending word, instr_valid=0. The state stays HALT until reset.
- FETCH_OPCODE_CHECK_EN undefined:
  - Every word is issued unchanged.
  - The illegal port and the HALT state are absent.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - the opcode localparams (R_TYPE 7'b0110011, I_TYPE 7'b0010011, S_TYPE 7'b0100011, SB_TYPE 7'b1100011, LOAD 7'b0000011), shared with the Controller;
  - the fetch_state_t enum.
- One sub-module, fetch_opcode_check: a combinational legality decode, instantiated only under FETCH_OPCODE_CHECK_EN.

## Test plan
- Reset, start=1, memory returns 32'h0020_8033 with gnt and rvalid immediate -> instr_valid in cycle 3, opcode=7'b0110011, instr_pc=0. Next imem_addr=4.
- instr_ready=0 for 5 cycles in ISSUE -> instr, opcode and instr_pc stable and no imem_req. Ready=1 -> the next request goes to pc+4.
- branch_taken=1 with target 32'h0000_0103 in WAIT -> the pending response is dropped (no instr_valid) and the next imem_addr=32'h0000_0100.
- branch_taken on the same cycle as an ISSUE handshake at pc 8, target 32'h40 -> next imem_addr=32'h40, not 32'hC.
- RESET_PC=32'hFFFF_FFFC, one instruction consumed -> next imem_addr=0.
- With FETCH_OPCODE_CHECK_EN, a word with opcode 7'b1111111 -> HALT, illegal=1, instr_valid stays 0, no further imem_req until reset.
